// File: rtl/mod7_stream_acc.sv
// mod7_stream_acc
//   Streams an operand in one nibble per accepted transfer, most-significant
//   nibble first, and produces the operand's remainder modulo 7 once the
//   nibble flagged with in_last has been taken.
//
//   Optional feature: define MOD7_NIBBLE_COUNT_EN to add the out_count port,
//   which reports the number of nibbles in the frame, saturating at 255.
//
// Ports
//   clk        sole clock; all state changes on its rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream offers in_nibble
//   in_ready   block can take a nibble this cycle (low while a result waits)
//   in_nibble  operand nibble, bit 3 is the MSB
//   in_last    in_nibble is the final, least-significant nibble
//   out_valid  out_rem holds a completed remainder
//   out_ready  downstream takes out_rem this cycle
//   out_rem    operand mod 7, range 0..6
//   out_count  nibbles in the completed frame (MOD7_NIBBLE_COUNT_EN only)
module mod7_stream_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_nibble,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_rem
`ifdef MOD7_NIBBLE_COUNT_EN
  ,
  output logic [7:0] out_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] r_q, r_d;
  logic [2:0] out_rem_q, out_rem_d;

  logic       accept;
  logic [2:0] r_base;
  logic [4:0] sum;
  logic [2:0] r_next;

  // Reduce a value in 0..27 to 0..6 using at most one fixed subtraction.
  function automatic logic [2:0] mod7_5b(input logic [4:0] v);
    logic [4:0] t;
    if (v >= 5'd21)      t = v - 5'd21;
    else if (v >= 5'd14) t = v - 5'd14;
    else if (v >= 5'd7)  t = v - 5'd7;
    else                 t = v;
    return t[2:0];
  endfunction

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_rem   = out_rem_q;
  assign accept    = in_valid && in_ready;

  // A new frame starts from r = 0, whatever r_q still holds.
  // 16 mod 7 = 2, so shifting in a nibble doubles the remainder.
  always_comb begin
    r_base = (state_q == IDLE) ? 3'd0 : r_q;
    sum    = {1'b0, r_base, 1'b0} + {1'b0, in_nibble};
    r_next = mod7_5b(sum);
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    out_rem_d = out_rem_q;
    unique case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          if (in_last) begin
            state_d   = DONE;
            r_d       = '0;
            out_rem_d = r_next;
          end else begin
            state_d   = ACC;
            r_d       = r_next;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        r_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      r_q       <= '0;
      out_rem_q <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      out_rem_q <= out_rem_d;
    end
  end

`ifdef MOD7_NIBBLE_COUNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] out_count_q, out_count_d;
  logic [7:0] cnt_next;

  always_comb begin
    if (state_q == IDLE)     cnt_next = 8'd1;
    else if (cnt_q == '1)    cnt_next = cnt_q;
    else                     cnt_next = cnt_q + 8'd1;

    cnt_d       = cnt_q;
    out_count_d = out_count_q;
    if (accept) begin
      cnt_d = cnt_next;
      if (in_last) out_count_d = cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      out_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_count = out_count_q;
`endif

endmodule
